dmem_ctrl: RTL and testbench
============================

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter DEPTH_WORDS, default 512: memory depth in 32-bit words; SHALL be a power of two, at least 4.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000: byte address of word 0; SHALL be aligned to 4*DEPTH_WORDS.
REQ-003 Parameter LATENCY, default 1: cycles from accept to response; legal range 1..4.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset; asynchronous, active-high.
REQ-006 req_valid  in  1  request present.
REQ-007 req_ready  out  1  controller can accept a request.
REQ-008 req_we  in  1  1 = store, 0 = load.
REQ-009 req_addr  in  32  byte address.
REQ-010 req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-011 req_unsigned  in  1  zero-extend loads (LBU/LHU) when 1.
REQ-012 req_wdata  in  32  store data, right-justified.
REQ-013 rsp_valid  out  1  response present.
REQ-014 rsp_ready  in  1  consumer accepts response.
REQ-015 rsp_rdata  out  32  extended load data; 0 for stores and errors.
REQ-016 rsp_err  out  2  00 = ok, 01 = misaligned, 10 = out of range, 11 = illegal size.

Function
REQ-017 Accept occurs on a rising edge with req_valid=1 and req_ready=1; all request fields SHALL be latched at accept.
REQ-018 FSM states: IDLE, BUSY, RESP; req_ready=1 only in IDLE; rsp_valid=1 only in RESP.
REQ-019 IDLE -> RESP on accept if LATENCY=1; IDLE -> BUSY with counter=LATENCY-2 if LATENCY>1.
REQ-020 BUSY decrements the counter each cycle; BUSY -> RESP on the cycle the counter is 0.
REQ-021 rsp_valid SHALL rise exactly LATENCY cycles after the accept edge; rsp_rdata and rsp_err SHALL be stable while rsp_valid=1.
REQ-022 RESP -> IDLE on an edge with rsp_ready=1; RESP holds otherwise, with no timeout.
REQ-023 Exactly one response per accepted request; at most one request outstanding; a new accept is possible on the edge after the response is consumed.
REQ-024 Error priority: illegal size (11), then misaligned (01), then out of range (10).
REQ-025 Misaligned: half with addr[0]=1; word with addr[1:0]!=0; bytes are never misaligned.
REQ-026 Out of range: addr < BASE_ADDR or addr >= BASE_ADDR + 4*DEPTH_WORDS, computed without 32-bit wrap.
REQ-027 Word index = (addr - BASE_ADDR) >> 2, truncated to log2(DEPTH_WORDS) bits.
REQ-028 An errored request SHALL NOT modify memory; rsp_rdata=0.
REQ-029 Store writes memory at the accept edge, byte-enabled: byte writes lane addr[1:0] with wdata[7:0]; half writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0]; word writes all lanes; other lanes are unchanged.
REQ-030 Load reads the word at the accept edge; byte selects lane addr[1:0] and half selects lane pair addr[1]; sign-extend unless req_unsigned=1; req_unsigned is ignored for word loads.
REQ-031 A load following a store to the same word SHALL return the post-store data.

Reset
REQ-032 While rst=1: state=IDLE, counter=0, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=00, independent of clk.
REQ-033 Reset mid-transaction abandons it and no response is issued; a store already written at its accept edge persists.
REQ-034 Memory contents SHALL NOT be initialised or cleared by reset.

Verification
REQ-035 LATENCY=1: SW 0xDEADBEEF @0x10, then LW @0x10 -> rsp_valid one cycle after each accept; load rdata=0xDEADBEEF, err=00.
REQ-036 SB 0x80 @0x11 over the stored word; LB @0x11 -> 0xFFFFFF80; LBU @0x11 -> 0x00000080; LW @0x10 -> 0xDEAD80EF.
REQ-037 LH @0x12 -> 0xFFFFDEAD; LHU @0x12 -> 0x0000DEAD; LH @0x13 -> err=01; LW @0x12 -> err=01; a word at 0x10 is unchanged by these.
REQ-038 LW @0x800 (DEPTH 512, BASE 0) -> err=10, rdata=0; size=11 @0x801 -> err=11 (priority); SW @0x800 -> err=10, no memory write.
REQ-039 LATENCY=3, rsp_ready held 0 for 5 cycles -> rsp_valid rises 3 cycles after accept, data held stable, req_ready=0 until consumed.
REQ-040 Assert rst while in BUSY -> rsp_valid=0 and req_ready=1 immediately; a subsequent read of a word stored before reset returns the stored data.

Source files
------------

// File: rtl/dmem_ctrl_if.sv
// Request/response bus between a load/store unit and the data memory controller.
// The master issues requests and consumes responses; the controller is the slave.
interface dmem_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_ctrl.sv
// Single-outstanding data memory controller with byte-enabled stores, sign/zero
// extending loads, error classification and a fixed, parameterised response latency.
module dmem_ctrl #(
  parameter int          DEPTH_WORDS = 512,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          LATENCY     = 1
) (
  input logic        clk,
  input logic        rst,
  dmem_ctrl_if.slave bus
);

  localparam int          AW    = $clog2(DEPTH_WORDS);
  localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q;
  logic [1:0]  err_q;

  logic [31:0]   mem [DEPTH_WORDS];
  logic          accept;
  logic [AW-1:0] idx;
  logic [1:0]    err_d;
  logic          misaligned, out_of_range;
  logic [31:0]   word, load_data, rdata_d, wlanes, wr_word;
  logic [7:0]    lane_b;
  logic [15:0]   lane_h;
  logic [3:0]    be;

  assign accept = bus.req_valid && (state_q == IDLE);
  assign idx    = AW'((bus.req_addr - BASE_ADDR) >> 2);
  assign word   = mem[idx];

  // Classification uses 33-bit compares so a window ending at 2^32 does not wrap.
  always_comb begin
    misaligned   = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                   ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));
    out_of_range = ({1'b0, bus.req_addr} < {1'b0, BASE_ADDR}) ||
                   ({1'b0, bus.req_addr} >= LIMIT);
    if (bus.req_size == 2'b11) err_d = 2'b11;
    else if (misaligned)       err_d = 2'b01;
    else if (out_of_range)     err_d = 2'b10;
    else                       err_d = 2'b00;
  end

  always_comb begin
    lane_b = word[8*bus.req_addr[1:0] +: 8];
    lane_h = bus.req_addr[1] ? word[31:16] : word[15:0];
    case (bus.req_size)
      2'b00:   load_data = {{24{~bus.req_unsigned & lane_b[7]}}, lane_b};
      2'b01:   load_data = {{16{~bus.req_unsigned & lane_h[15]}}, lane_h};
      default: load_data = word;
    endcase
    rdata_d = (err_d == 2'b00 && !bus.req_we) ? load_data : 32'h0;
  end

  // Stores replicate the data across lanes and merge only the enabled bytes.
  always_comb begin
    case (bus.req_size)
      2'b00:   begin be = 4'b0001 << bus.req_addr[1:0]; wlanes = {4{bus.req_wdata[7:0]}}; end
      2'b01:   begin be = bus.req_addr[1] ? 4'b1100 : 4'b0011; wlanes = {2{bus.req_wdata[15:0]}}; end
      2'b10:   begin be = 4'b1111; wlanes = bus.req_wdata; end
      default: begin be = 4'b0000; wlanes = bus.req_wdata; end
    endcase
    wr_word = word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) wr_word[8*i +: 8] = wlanes[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (accept && bus.req_we && err_d == 2'b00) mem[idx] <= wr_word;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (bus.req_valid) begin
        if (LATENCY == 1) state_d = RESP;
        else begin
          state_d = BUSY;
          cnt_d   = 2'(LATENCY - 2);
        end
      end
      BUSY: if (cnt_q == 2'd0) state_d = RESP;
            else               cnt_d   = cnt_q - 2'd1;
      RESP: if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      rdata_q <= 32'h0;
      err_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        rdata_q <= rdata_d;
        err_q   <= err_d;
      end
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench: two controllers (LATENCY 1 and 3) checked against a
// byte-addressed reference memory with directed and random transactions.
module tb_dmem_ctrl;
  localparam int          D0 = 512;
  localparam logic [31:0] B0 = 32'h0000_0000;
  localparam int          L0 = 1;
  localparam int          D1 = 64;
  localparam logic [31:0] B1 = 32'h0000_1000;
  localparam int          L1 = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req_valid [2];
  logic        rsp_ready [2];
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;

  logic        obs_valid [2];
  logic        obs_ready [2];
  logic [31:0] obs_rdata [2];
  logic [1:0]  obs_err   [2];

  dmem_ctrl_if bus0 ();
  dmem_ctrl_if bus1 ();

  assign bus0.req_valid = req_valid[0];
  assign bus0.rsp_ready = rsp_ready[0];
  assign bus0.req_we = req_we;
  assign bus0.req_addr = req_addr;
  assign bus0.req_size = req_size;
  assign bus0.req_unsigned = req_unsigned;
  assign bus0.req_wdata = req_wdata;
  assign bus1.req_valid = req_valid[1];
  assign bus1.rsp_ready = rsp_ready[1];
  assign bus1.req_we = req_we;
  assign bus1.req_addr = req_addr;
  assign bus1.req_size = req_size;
  assign bus1.req_unsigned = req_unsigned;
  assign bus1.req_wdata = req_wdata;

  assign obs_valid[0] = bus0.rsp_valid;
  assign obs_ready[0] = bus0.req_ready;
  assign obs_rdata[0] = bus0.rsp_rdata;
  assign obs_err[0]   = bus0.rsp_err;
  assign obs_valid[1] = bus1.rsp_valid;
  assign obs_ready[1] = bus1.req_ready;
  assign obs_rdata[1] = bus1.rsp_rdata;
  assign obs_err[1]   = bus1.rsp_err;

  dmem_ctrl #(.DEPTH_WORDS(D0), .BASE_ADDR(B0), .LATENCY(L0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  dmem_ctrl #(.DEPTH_WORDS(D1), .BASE_ADDR(B1), .LATENCY(L1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int n_cmp = 0;
  int n_err = 0;

  // Reference memory: one byte per key, key = (dut << 40) | byte address.
  logic [7:0] model_mem [longint];

  function automatic void model(input int s, input logic we, input logic [31:0] addr,
                                input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                                output logic [31:0] rdata, output logic [1:0] err);
    longint base, lim, a, v, key;
    int nb;
    base = (s == 0) ? longint'(B0) : longint'(B1);
    lim  = base + 4 * longint'((s == 0) ? D0 : D1);
    a    = longint'(addr);
    nb   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    if (size == 2'd3)            err = 2'b11;
    else if (a % nb != 0)        err = 2'b01;
    else if (a < base || a >= lim) err = 2'b10;
    else                         err = 2'b00;
    rdata = 32'h0;
    if (err == 2'b00) begin
      key = (longint'(s) << 40) | a;
      if (we) begin
        for (int i = 0; i < nb; i++) model_mem[key + i] = wdata[8*i +: 8];
      end else begin
        v = 0;
        for (int i = 0; i < nb; i++) v = v | (longint'(model_mem[key + i]) << (8 * i));
        if (!uns && nb < 4 && v >= (longint'(1) << (8 * nb - 1))) v = v - (longint'(1) << (8 * nb));
        rdata = v[31:0];
      end
    end
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input int s, input string tag, input logic we, input logic [31:0] addr,
                                input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                                input int stall, output logic [31:0] got_rdata, output logic [1:0] got_err);
    logic [31:0] exp_rd;
    logic [1:0]  exp_er;
    int lat;
    model(s, we, addr, size, uns, wdata, exp_rd, exp_er);
    check_output({tag, ".ready_before"}, 32'(obs_ready[s]), 32'd1);
    req_we = we; req_addr = addr; req_size = size; req_unsigned = uns; req_wdata = wdata;
    req_valid[s] = 1'b1;
    @(posedge clk); #1;
    req_valid[s] = 1'b0;
    lat = 1;
    while (obs_valid[s] !== 1'b1 && lat < 16) begin
      @(posedge clk); #1;
      lat++;
    end
    check_output({tag, ".latency"}, 32'(lat), 32'((s == 0) ? L0 : L1));
    check_output({tag, ".rdata"}, obs_rdata[s], exp_rd);
    check_output({tag, ".err"}, 32'(obs_err[s]), 32'(exp_er));
    got_rdata = obs_rdata[s];
    got_err   = obs_err[s];
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check_output({tag, ".hold_valid"}, 32'(obs_valid[s]), 32'd1);
      check_output({tag, ".hold_ready"}, 32'(obs_ready[s]), 32'd0);
      check_output({tag, ".hold_rdata"}, obs_rdata[s], exp_rd);
      check_output({tag, ".hold_err"}, 32'(obs_err[s]), 32'(exp_er));
    end
    rsp_ready[s] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[s] = 1'b0;
    check_output({tag, ".valid_after"}, 32'(obs_valid[s]), 32'd0);
    check_output({tag, ".ready_after"}, 32'(obs_ready[s]), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int s = 0; s < 2; s++) begin
      check_output({tag, ".req_ready"}, 32'(obs_ready[s]), 32'd1);
      check_output({tag, ".rsp_valid"}, 32'(obs_valid[s]), 32'd0);
      check_output({tag, ".rsp_rdata"}, obs_rdata[s], 32'h0);
      check_output({tag, ".rsp_err"}, 32'(obs_err[s]), 32'd0);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] rd, dummy_rd, base, addr;
    logic [1:0]  er, size;
    int depth, r;

    rst = 1'b1;
    req_valid[0] = 1'b0; req_valid[1] = 1'b0;
    rsp_ready[0] = 1'b0; rsp_ready[1] = 1'b0;
    req_we = 1'b0; req_addr = 32'h0; req_size = 2'd0; req_unsigned = 1'b0; req_wdata = 32'h0;

    #3;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] LATENCY=1 word store/load");
    apply_stimulus(0, "sw10", 1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF, 0, rd, er);
    apply_stimulus(0, "lw10", 1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 0, rd, er);
    check_output("lw10.const", rd, 32'hDEADBEEF);

    $display("[TB] byte store and extended loads");
    apply_stimulus(0, "sb11", 1'b1, 32'h11, 2'd0, 1'b0, 32'h0000_0080, 0, rd, er);
    apply_stimulus(0, "lb11", 1'b0, 32'h11, 2'd0, 1'b0, 32'h0, 0, rd, er);
    check_output("lb11.const", rd, 32'hFFFFFF80);
    apply_stimulus(0, "lbu11", 1'b0, 32'h11, 2'd0, 1'b1, 32'h0, 0, rd, er);
    check_output("lbu11.const", rd, 32'h00000080);
    apply_stimulus(0, "lw10b", 1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 0, rd, er);
    check_output("lw10b.const", rd, 32'hDEAD80EF);

    $display("[TB] half loads and misalignment");
    apply_stimulus(0, "lh12", 1'b0, 32'h12, 2'd1, 1'b0, 32'h0, 0, rd, er);
    check_output("lh12.const", rd, 32'hFFFFDEAD);
    apply_stimulus(0, "lhu12", 1'b0, 32'h12, 2'd1, 1'b1, 32'h0, 0, rd, er);
    check_output("lhu12.const", rd, 32'h0000DEAD);
    apply_stimulus(0, "lh13", 1'b0, 32'h13, 2'd1, 1'b0, 32'h0, 0, rd, er);
    check_output("lh13.const_err", 32'(er), 32'd1);
    apply_stimulus(0, "lw12", 1'b0, 32'h12, 2'd2, 1'b0, 32'h0, 0, rd, er);
    check_output("lw12.const_err", 32'(er), 32'd1);
    apply_stimulus(0, "lw10c", 1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 0, rd, er);
    check_output("lw10c.const", rd, 32'hDEAD80EF);

    $display("[TB] range and illegal size");
    apply_stimulus(0, "sw0", 1'b1, 32'h0, 2'd2, 1'b0, 32'h11223344, 0, rd, er);
    apply_stimulus(0, "lw800", 1'b0, 32'h800, 2'd2, 1'b0, 32'h0, 0, rd, er);
    check_output("lw800.const_err", 32'(er), 32'd2);
    check_output("lw800.const_rdata", rd, 32'h0);
    apply_stimulus(0, "ill801", 1'b0, 32'h801, 2'd3, 1'b0, 32'h0, 0, rd, er);
    check_output("ill801.const_err", 32'(er), 32'd3);
    apply_stimulus(0, "sw800", 1'b1, 32'h800, 2'd2, 1'b0, 32'hFFFFFFFF, 0, rd, er);
    check_output("sw800.const_err", 32'(er), 32'd2);
    apply_stimulus(0, "lw0", 1'b0, 32'h0, 2'd2, 1'b0, 32'h0, 0, rd, er);
    check_output("lw0.const", rd, 32'h11223344);

    $display("[TB] LATENCY=3 with back-pressure");
    apply_stimulus(1, "sw1008", 1'b1, 32'h1008, 2'd2, 1'b0, 32'h12345678, 0, rd, er);
    apply_stimulus(1, "lw1008", 1'b0, 32'h1008, 2'd2, 1'b0, 32'h0, 5, rd, er);
    check_output("lw1008.const", rd, 32'h12345678);

    $display("[TB] reset while busy");
    apply_stimulus(1, "sw1020", 1'b1, 32'h1020, 2'd2, 1'b0, 32'hA5A55A5A, 0, rd, er);
    model(1, 1'b1, 32'h1024, 2'd2, 1'b0, 32'hCAFEF00D, dummy_rd, er);
    req_we = 1'b1; req_addr = 32'h1024; req_size = 2'd2; req_unsigned = 1'b0; req_wdata = 32'hCAFEF00D;
    req_valid[1] = 1'b1;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    check_output("busy.ready", 32'(obs_ready[1]), 32'd0);
    check_output("busy.valid", 32'(obs_valid[1]), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("midreset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_output("postreset.valid", 32'(obs_valid[1]), 32'd0);
    apply_stimulus(1, "lw1020", 1'b0, 32'h1020, 2'd2, 1'b0, 32'h0, 0, rd, er);
    check_output("lw1020.const", rd, 32'hA5A55A5A);
    apply_stimulus(1, "lw1024", 1'b0, 32'h1024, 2'd2, 1'b0, 32'h0, 0, rd, er);
    check_output("lw1024.const", rd, 32'hCAFEF00D);

    $display("[TB] random transactions");
    for (int s = 0; s < 2; s++) begin
      base  = (s == 0) ? B0 : B1;
      depth = (s == 0) ? D0 : D1;
      for (int w = 0; w < 8; w++) begin
        apply_stimulus(s, "rnd_init", 1'b1, base + 32'(4 * w), 2'd2, 1'b0, $urandom, 0, rd, er);
      end
      for (int n = 0; n < 60; n++) begin
        r = $urandom_range(0, 9);
        if (r == 0)      addr = base + 32'(4 * depth) + 32'($urandom_range(0, 7));
        else if (r == 1) addr = $urandom | 32'h8000_0000;
        else             addr = base + 32'($urandom_range(0, 31));
        r = $urandom_range(0, 7);
        size = (r < 3) ? 2'd0 : (r < 5) ? 2'd1 : (r < 7) ? 2'd2 : 2'd3;
        apply_stimulus(s, "rnd", 1'($urandom_range(0, 1)), addr, size, 1'($urandom_range(0, 1)),
                       $urandom, $urandom_range(0, 2), rd, er);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
